// File: rtl/pipe_stage_skid_pkg.sv
// Shared state encoding and the default NOP word for the pipeline-stage register.
package pipe_stage_skid_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload+PC entry: a load-enabled register with asynchronous active-low clear.
module pipe_stage_skid_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the data word is reset too, because out_instr/out_addr must read 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with flush-to-NOP, hold, and an optional 2-entry skid.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W          = 32,
  parameter int              ADDR_W          = 32,
  parameter logic [DATA_W-1:0] NOP_VAL       = DATA_W'(MIPS_NOP),
  parameter bit              FLUSH_KEEP_ADDR = 1'b1,
  parameter bit              SKID            = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_bubble,
  output logic [1:0]        occupancy
);

  localparam int W = DATA_W + ADDR_W;

  state_t              state, state_next;
  logic                in_fire, out_fire;
  logic                main_load, main_from_skid, skid_load;
  logic [W-1:0]        main_d, main_q, skid_q;
  logic [ADDR_W-1:0]   flush_addr;

  assign out_valid  = (state != ST_EMPTY);
  assign out_fire   = out_valid & out_ready & ~hold;
  assign in_fire    = in_valid & in_ready;
  assign occupancy  = state;
  assign {out_instr, out_addr} = main_q;
  assign flush_addr = FLUSH_KEEP_ADDR ? out_addr : '0;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      main_load  = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: if (in_fire) begin
          state_next = ST_ONE;
          main_load  = 1'b1;
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID) begin
            state_next = ST_FULL;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: if (out_fire) begin
          state_next     = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_d = {in_instr, in_addr};
    if (flush) begin
      main_d = {NOP_VAL, flush_addr};
    end else if (main_from_skid) begin
      main_d = skid_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      out_bubble <= 1'b0;
    end else begin
      state <= state_next;
      if (flush) begin
        out_bubble <= 1'b1;
      end else if (main_load) begin
        out_bubble <= 1'b0;
      end
    end
  end

  pipe_stage_skid_slot #(.W(W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      pipe_stage_skid_slot #(.W(W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     ({in_instr, in_addr}),
        .q     (skid_q)
      );

      // Registered ready: only a transition into FULL closes the input side.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_next != ST_FULL);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_no_skid
      assign skid_q   = '0;
      assign in_ready = ~out_valid | out_fire;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: default build, a FLUSH_KEEP_ADDR=0 build and a SKID=0 build share one stimulus.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, hold, in_valid, out_ready;
  logic [31:0] in_instr, in_addr;

  logic        a_in_ready, a_out_valid, a_out_bubble;
  logic [31:0] a_out_instr, a_out_addr;
  logic [1:0]  a_occ;
  logic        b_in_ready, b_out_valid, b_out_bubble;
  logic [31:0] b_out_instr, b_out_addr;
  logic [1:0]  b_occ;
  logic        c_in_ready, c_out_valid, c_out_bubble;
  logic [31:0] c_out_instr, c_out_addr;
  logic [1:0]  c_occ;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut_a (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_addr(in_addr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_addr(a_out_addr), .out_bubble(a_out_bubble), .occupancy(a_occ)
  );

  pipe_stage_skid #(.FLUSH_KEEP_ADDR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_addr(in_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_addr(b_out_addr), .out_bubble(b_out_bubble), .occupancy(b_occ)
  );

  pipe_stage_skid #(.SKID(1'b0)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr), .in_addr(in_addr),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_instr(c_out_instr),
    .out_addr(c_out_addr), .out_bubble(c_out_bubble), .occupancy(c_occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] addr);
    in_valid = 1'b1;
    in_instr = instr;
    in_addr  = addr;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_addr = '0;
    #12;
    check("rst_valid",  a_out_valid, 0);
    check("rst_instr",  a_out_instr, 0);
    check("rst_addr",   a_out_addr, 0);
    check("rst_bubble", a_out_bubble, 0);
    check("rst_occ",    a_occ, 0);
    check("rst_ready",  a_in_ready, 1);
    tick();
    reset = 1'b1;

    // 1: single beat, one-cycle latency
    push(32'h8C22_0004, 32'h0040_0000); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", a_out_valid, 1);
    check("t1_instr", a_out_instr, 32'h8C22_0004);
    check("t1_addr",  a_out_addr, 32'h0040_0000);
    check("t1_occ",   a_occ, 1);
    tick();
    check("t1_drain", a_occ, 0);

    // 2: back-pressure fills the skid, then drains in order
    out_ready = 1'b0;
    push(32'h11, 32'h100);
    tick();
    check("t2_ready1", a_in_ready, 1);
    push(32'h22, 32'h104);
    tick();
    in_valid = 1'b0;
    check("t2_occ2",   a_occ, 2);
    check("t2_ready2", a_in_ready, 0);
    check("t2_headA",  a_out_instr, 32'h11);
    out_ready = 1'b1;
    tick();
    check("t2_headB",  a_out_instr, 32'h22);
    check("t2_addrB",  a_out_addr, 32'h104);
    check("t2_occ1",   a_occ, 1);
    check("t2_ready3", a_in_ready, 1);
    tick();
    check("t2_empty",  a_out_valid, 0);

    // 3: full-rate stream
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + i, 32'h0040_0000 + 4 * i);
      tick();
      check("t3_ready", a_in_ready, 1);
      check("t3_instr", a_out_instr, 32'h1000 + i);
      check("t3_addr",  a_out_addr, 32'h0040_0000 + 4 * i);
    end
    in_valid = 1'b0;
    tick();
    check("t3_drain", a_occ, 0);

    // 4: flush while FULL
    out_ready = 1'b0;
    push(32'h33, 32'h0040_0010);
    tick();
    push(32'h44, 32'h0040_0014);
    tick();
    in_valid = 1'b0;
    check("t4_full", a_occ, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_valid",   a_out_valid, 0);
    check("t4_instr",   a_out_instr, 32'h0);
    check("t4_addr",    a_out_addr, 32'h0040_0010);
    check("t4_bubble",  a_out_bubble, 1);
    check("t4_occ",     a_occ, 0);
    check("t4_ready",   a_in_ready, 1);
    check("t4_addr_nk", b_out_addr, 32'h0);
    check("t4_bub_nk",  b_out_bubble, 1);
    out_ready = 1'b1;
    push(32'h55, 32'h200);
    tick();
    in_valid = 1'b0;
    check("t4_unbubble", a_out_bubble, 0);
    check("t4_reload",   a_out_instr, 32'h55);
    tick();
    check("t4_keep_valid", a_out_valid, 0);
    check("t4_keep_instr", a_out_instr, 32'h55);

    // 5: hold freezes a live beat; flush beats hold and the incoming beat
    hold = 1'b1;
    push(32'hDEAD_BEEF, 32'h300);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hvalid", a_out_valid, 1);
      check("t5_hinstr", a_out_instr, 32'hDEAD_BEEF);
      check("t5_haddr",  a_out_addr, 32'h300);
      check("t5_hocc",   a_occ, 1);
    end
    hold = 1'b0;
    tick();
    check("t5_release", a_occ, 0);
    hold = 1'b1;
    push(32'h66, 32'h400);
    tick();
    push(32'h77, 32'h500);
    flush = 1'b1;
    tick();
    flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    check("t5_fvalid",  a_out_valid, 0);
    check("t5_finstr",  a_out_instr, 32'h0);
    check("t5_faddr",   a_out_addr, 32'h400);
    check("t5_fbubble", a_out_bubble, 1);
    check("t5_focc",    a_occ, 0);
    check("t5_faddr_nk", b_out_addr, 32'h0);

    // 6: SKID=0 combinational ready, then async reset mid-cycle
    reset = 1'b0;
    #2;
    reset = 1'b1;
    push(32'h81, 32'h600); out_ready = 1'b1;
    #1;
    check("t6_rdy_empty", c_in_ready, 1);
    tick();
    check("t6_instr81", c_out_instr, 32'h81);
    push(32'h82, 32'h604);
    #1;
    check("t6_rdy_or1", c_in_ready, 1);
    tick();
    out_ready = 1'b0;
    push(32'h83, 32'h608);
    #1;
    check("t6_rdy_or0", c_in_ready, 0);
    check("t6_occ",     c_occ, 1);
    tick();
    check("t6_stall",   c_out_instr, 32'h82);
    out_ready = 1'b1;
    #1;
    check("t6_rdy_or1b", c_in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t6_instr83", c_out_instr, 32'h83);
    check("t6_occ_max", c_occ, 1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", c_out_valid, 0);
    check("t6_rst_instr", c_out_instr, 0);
    check("t6_rst_addr",  c_out_addr, 0);
    check("t6_rst_occ",   c_occ, 0);
    check("t6_rst_ready", c_in_ready, 1);
    check("t6_rst_bub",   c_out_bubble, 0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
